// File: rtl/inertial_integrator_cal_pkg.sv
// Shared types and helpers for the pitch integrator.
//   integ_state_t  : RUN (integrate + fuse) / CAL (average gyro rate to find offset)
//   AZ_OFFSET_DEF  : default accelerometer Z offset
//   RT_OFFSET_DEF  : default gyro offset, restored on every reset
//   sat()          : clamp a signed value to a signed range of the given width
package inertial_pkg;

  typedef enum logic {RUN = 1'b0, CAL = 1'b1} integ_state_t;

  localparam logic [15:0] AZ_OFFSET_DEF = 16'hFE80;
  localparam logic [15:0] RT_OFFSET_DEF = 16'h03C2;

  function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/inertial_integrator_cal_if.sv
// Sensor-side / controller-side bundle of the pitch integrator.
//   master : drives vld, ptch_rt, AZ, cal_start; observes ptch, rt_offset, cal_busy, cal_done
//   slave  : the integrator itself
interface inertial_integrator_cal_if #(
  parameter int RT_W = 16
);
  logic                   vld;
  logic signed [RT_W-1:0] ptch_rt;
  logic signed [RT_W-1:0] AZ;
  logic                   cal_start;
  logic signed [RT_W-1:0] ptch;
  logic signed [RT_W-1:0] rt_offset;
  logic                   cal_busy;
  logic                   cal_done;

  modport master (
    output vld, ptch_rt, AZ, cal_start,
    input  ptch, rt_offset, cal_busy, cal_done
  );

  modport slave (
    input  vld, ptch_rt, AZ, cal_start,
    output ptch, rt_offset, cal_busy, cal_done
  );
endinterface

// File: rtl/inertial_integrator_cal_rate_offset_cal.sv
// Gyro offset calibration engine: sums 2**CAL_LOG2 rate samples and returns
// their floor average.
//   clk, rst_n : clock, async active-low reset
//   clr        : clear accumulator and sample counter
//   vld        : sample valid (already gated to the calibration window)
//   ptch_rt    : signed gyro rate sample
//   avg        : floor average including the current sample
//   avg_vld    : high on the final sample of the window (avg meaningful then)
module rate_offset_cal #(
  parameter int RT_W     = 16,
  parameter int CAL_LOG2 = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   vld,
  input  logic signed [RT_W-1:0] ptch_rt,
  output logic signed [RT_W-1:0] avg,
  output logic                   avg_vld
);
  localparam int AW = RT_W + CAL_LOG2;

  logic signed [AW-1:0]  cal_acc_q, cal_acc_d, acc_next;
  logic [CAL_LOG2-1:0]   cal_cnt_q, cal_cnt_d;

  always_comb begin
    acc_next  = cal_acc_q + AW'(ptch_rt);
    // Final sample is folded in combinationally so the average is ready on
    // the same edge that closes the window.
    avg_vld   = vld && (cal_cnt_q == '1);
    avg       = RT_W'(acc_next >>> CAL_LOG2);
    cal_acc_d = cal_acc_q;
    cal_cnt_d = cal_cnt_q;
    if (clr) begin
      cal_acc_d = '0;
      cal_cnt_d = '0;
    end else if (vld) begin
      cal_acc_d = acc_next;
      cal_cnt_d = cal_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_acc_q <= '0;
      cal_cnt_q <= '0;
    end else begin
      cal_acc_q <= cal_acc_d;
      cal_cnt_q <= cal_cnt_d;
    end
  end
endmodule

// File: rtl/inertial_integrator_cal.sv
// Complementary-filter pitch integrator with on-demand gyro offset calibration.
// Integrates offset-compensated pitch rate on each vld, leaks the integral by
// +/-FUSION_STEP toward the accelerometer pitch, and saturates instead of wrapping.
//   clk, rst_n : clock, async active-low reset
//   bus.vld, bus.ptch_rt, bus.AZ, bus.cal_start : sensor samples and cal request
//   bus.ptch      : fused pitch (integrator integer part)
//   bus.rt_offset : gyro offset in use
//   bus.cal_busy  : high while calibrating
//   bus.cal_done  : one-cycle pulse when a new offset is loaded
module inertial_integrator_cal
  import inertial_pkg::*;
#(
  parameter int              RT_W          = 16,
  parameter int              INT_FRAC      = 11,
  parameter logic [RT_W-1:0] AZ_OFFSET     = AZ_OFFSET_DEF,
  parameter logic [RT_W-1:0] RT_OFFSET_RST = RT_OFFSET_DEF,
  parameter int              ACC_GAIN      = 327,
  parameter int              ACC_SHIFT     = 13,
  parameter int              FUSION_STEP   = 1024,
  parameter int              CAL_LOG2      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  inertial_integrator_cal_if.slave   bus
);
  localparam int IW = RT_W + INT_FRAC;
  localparam int PW = RT_W + 33;

  integ_state_t           state_q, state_d;
  logic signed [IW-1:0]   integ_q, integ_d;
  logic signed [RT_W-1:0] rt_offset_q, rt_offset_d;
  logic                   cal_done_q, cal_done_d;

  logic signed [RT_W:0]   rt_c, az_c;
  logic signed [PW-1:0]   prod, shifted;
  logic signed [RT_W-1:0] acc_p, ptch;
  logic signed [IW+1:0]   fus, sum;
  logic signed [RT_W-1:0] avg;
  logic                   avg_vld, cal_clr, cal_vld;

  assign ptch    = integ_q[IW-1:INT_FRAC];
  assign cal_clr = (state_q == RUN) && bus.cal_start;
  assign cal_vld = (state_q == CAL) && bus.vld;

  rate_offset_cal #(.RT_W(RT_W), .CAL_LOG2(CAL_LOG2)) u_cal (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cal_clr),
    .vld     (cal_vld),
    .ptch_rt (bus.ptch_rt),
    .avg     (avg),
    .avg_vld (avg_vld)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state: cal_start is ignored once calibrating
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.cal_start) state_d = CAL;
      CAL:     if (avg_vld)       state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.cal_busy = (state_q == CAL);
  end

  // Fusion datapath: both differences in RT_W+1 bits so they cannot overflow
  always_comb begin
    rt_c    = $signed({bus.ptch_rt[RT_W-1], bus.ptch_rt}) - $signed({rt_offset_q[RT_W-1], rt_offset_q});
    az_c    = $signed({bus.AZ[RT_W-1], bus.AZ}) - $signed({AZ_OFFSET[RT_W-1], AZ_OFFSET});
    prod    = PW'(az_c) * PW'(ACC_GAIN);
    shifted = prod >>> ACC_SHIFT;
    acc_p   = RT_W'(sat(64'(shifted), RT_W));
    // A tie pulls the integral down.
    fus     = (acc_p > ptch) ? (IW+2)'(FUSION_STEP) : -((IW+2)'(FUSION_STEP));
    sum     = (IW+2)'(integ_q) - (IW+2)'(rt_c) + fus;
  end

  always_comb begin
    integ_d     = integ_q;
    rt_offset_d = rt_offset_q;
    cal_done_d  = 1'b0;
    case (state_q)
      RUN: begin
        // Entering calibration clears the integral even if a sample arrives.
        if (bus.cal_start)  integ_d = '0;
        else if (bus.vld)   integ_d = IW'(sat(64'(sum), IW));
      end
      CAL: begin
        integ_d = '0;
        if (avg_vld) begin
          rt_offset_d = avg;
          cal_done_d  = 1'b1;
        end
      end
      default: integ_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_q     <= '0;
      rt_offset_q <= RT_OFFSET_RST;
      cal_done_q  <= 1'b0;
    end else begin
      integ_q     <= integ_d;
      rt_offset_q <= rt_offset_d;
      cal_done_q  <= cal_done_d;
    end
  end

  assign bus.ptch      = ptch;
  assign bus.rt_offset = rt_offset_q;
  assign bus.cal_done  = cal_done_q;
endmodule
